mem_stage_ctrl: RTL and testbench



---
 rtl/mem_stage_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage access controller between EX/MEM and the data cache
// Optional watchdog: define MEM_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYCLES cycles.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_EXMEM,
    input  logic [15:0] wdata_EXMEM,
    input  logic        MemRead_EXMEM,
    input  logic        MemWrite_EXMEM,
    input  logic        advance,
    output logic [15:0] mem_Addr,
    output logic [15:0] mem_DataIn,
    output logic        mem_Rd,
    output logic        mem_Wr,
    input  logic [15:0] mem_DataOut,
    input  logic        mem_Done,
    input  logic        mem_Stall,
    input  logic        mem_err,
    output logic [15:0] mem_read_data,
    output logic        data_mem_stall,
    output logic        data_mem_done,
    output logic        data_mem_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        served_q, served_d;
    logic [15:0] hold_q, hold_d;
    logic        err_q, err_d;

    logic        access;
    logic        misaligned;
    logic        aligned;
    logic        req;
    logic        done_ok;
    logic        timeout;

    assign access     = MemRead_EXMEM | MemWrite_EXMEM;
    assign misaligned = access & addr_EXMEM[0];
    assign aligned    = access & ~addr_EXMEM[0];

    // A request goes out only once per instruction, and only when the cache can take it.
    assign req = (state_q == S_IDLE) & aligned & ~served_q & ~mem_Stall;

    // A completion counts only when it belongs to our own outstanding or just-issued access;
    // a stray done (e.g. after a reset mid-WAIT) is ignored.
    assign done_ok = mem_Done & ((state_q == S_WAIT) | req);

`ifdef MEM_TIMEOUT_EN
    logic [4:0] cnt_q, cnt_d;

    assign timeout = (state_q == S_WAIT) & ~mem_Done & (cnt_q == 5'(TIMEOUT_CYCLES - 1));

    // Watchdog counter: runs only while waiting, restarts whenever WAIT is left.
    always_comb begin
        cnt_d = 5'd0;
        if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
            cnt_d = 5'(cnt_q + 5'd1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 5'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    // Next-state logic: request strobes, completion capture and per-instruction bookkeeping.
    always_comb begin
        state_d  = state_q;
        served_d = served_q;
        hold_d   = hold_q;
        err_d    = err_q;
        mem_Rd   = 1'b0;
        mem_Wr   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    // Read and write together is a read-modify cycle issued as a write.
                    mem_Wr = MemWrite_EXMEM;
                    mem_Rd = MemRead_EXMEM & ~MemWrite_EXMEM;
                    if (!mem_Done) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_Done || timeout) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (done_ok) begin
            served_d = 1'b1;
            hold_d   = mem_DataOut;
            err_d    = err_q | mem_err;
        end else if (timeout) begin
            served_d = 1'b1;
            err_d    = 1'b1;
        end

        // The instruction leaves MEM: everything captured for it is dropped, even a
        // completion arriving in this same cycle.
        if (advance) begin
            served_d = 1'b0;
            hold_d   = 16'h0000;
            err_d    = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            served_q <= 1'b0;
            hold_q   <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
        end
    end

    assign mem_Addr       = addr_EXMEM;
    assign mem_DataIn     = wdata_EXMEM;
    assign mem_read_data  = done_ok ? mem_DataOut : hold_q;
    assign data_mem_stall = aligned & ~served_q & ~done_ok;
    assign data_mem_done  = done_ok | served_q;
    assign data_mem_err   = (done_ok & mem_err) | err_q | misaligned;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed and randomized checks of mem_stage_ctrl against a reference model
module tb_mem_stage_ctrl;

    localparam int TO_CYCLES = 31;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr_EXMEM, wdata_EXMEM;
    logic        MemRead_EXMEM, MemWrite_EXMEM, advance;
    logic [15:0] mem_Addr, mem_DataIn;
    logic        mem_Rd, mem_Wr;
    logic [15:0] mem_DataOut;
    logic        mem_Done, mem_Stall, mem_err;
    logic [15:0] mem_read_data;
    logic        data_mem_stall, data_mem_done, data_mem_err;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk            (clk),
        .rst            (rst),
        .addr_EXMEM     (addr_EXMEM),
        .wdata_EXMEM    (wdata_EXMEM),
        .MemRead_EXMEM  (MemRead_EXMEM),
        .MemWrite_EXMEM (MemWrite_EXMEM),
        .advance        (advance),
        .mem_Addr       (mem_Addr),
        .mem_DataIn     (mem_DataIn),
        .mem_Rd         (mem_Rd),
        .mem_Wr         (mem_Wr),
        .mem_DataOut    (mem_DataOut),
        .mem_Done       (mem_Done),
        .mem_Stall      (mem_Stall),
        .mem_err        (mem_err),
        .mem_read_data  (mem_read_data),
        .data_mem_stall (data_mem_stall),
        .data_mem_done  (data_mem_done),
        .data_mem_err   (data_mem_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: per-instruction facts only (completed, outstanding, captured data/error).
    bit          m_served, m_pending, m_err;
    logic [15:0] m_hold;
    int          m_waited;
    int          strobes;

    bit          acc, mis, issue, ok;
    logic        e_rd, e_wr, e_stall, e_done, e_err;
    logic [15:0] e_rdata;

    int          stall_cnt, wr_cnt;

    function automatic void calc();
        acc     = MemRead_EXMEM | MemWrite_EXMEM;
        mis     = acc && addr_EXMEM[0];
        issue   = acc && !mis && !m_served && !m_pending && !mem_Stall;
        ok      = mem_Done && (m_pending || issue);
        e_rd    = issue && MemRead_EXMEM && !MemWrite_EXMEM;
        e_wr    = issue && MemWrite_EXMEM;
        e_stall = acc && !mis && !m_served && !ok;
        e_rdata = ok ? mem_DataOut : m_hold;
        e_done  = ok || m_served;
        e_err   = (ok && mem_err) || m_err || mis;
    endfunction

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                          input logic adv, input logic done, input logic [15:0] dout,
                          input logic stl, input logic er);
        MemRead_EXMEM  = rd;
        MemWrite_EXMEM = wr;
        addr_EXMEM     = a;
        wdata_EXMEM    = wd;
        advance        = adv;
        mem_Done       = done;
        mem_DataOut    = dout;
        mem_Stall      = stl;
        mem_err        = er;
    endtask

    // Compare all outputs mid-cycle against the model.
    task automatic step(input string tag);
        #4;
        calc();
        chk1({tag, ".rd"},    mem_Rd,         e_rd);
        chk1({tag, ".wr"},    mem_Wr,         e_wr);
        chk1({tag, ".stall"}, data_mem_stall, e_stall);
        chk1({tag, ".done"},  data_mem_done,  e_done);
        chk1({tag, ".err"},   data_mem_err,   e_err);
        chk16({tag, ".rdata"}, mem_read_data, e_rdata);
        if (mem_Rd || mem_Wr) strobes++;
        if (advance) chk16({tag, ".strobes"}, 16'(strobes), (acc && !mis) ? 16'd1 : 16'd0);
    endtask

    // Advance one clock and update the model.
    task automatic tick();
        @(posedge clk);
        calc();
        if (rst) begin
            m_served = 0; m_pending = 0; m_err = 0; m_hold = 16'h0000; m_waited = 0; strobes = 0;
        end else if (advance) begin
            m_served = 0; m_pending = 0; m_err = 0; m_hold = 16'h0000; m_waited = 0; strobes = 0;
        end else if (ok) begin
            m_served = 1; m_pending = 0; m_hold = mem_DataOut; m_err = m_err || mem_err;
        end else if (issue) begin
            m_pending = 1; m_waited = 0;
        end else if (m_pending) begin
`ifdef MEM_TIMEOUT_EN
            m_waited++;
            if (m_waited == TO_CYCLES) begin
                m_pending = 0; m_served = 1; m_err = 1;
            end
`endif
        end
        #1;
    endtask

    task automatic new_instr();
        int k;
        logic [15:0] a;
        k = $urandom_range(0, 3);
        a = 16'($urandom) & 16'hFFFE;
        if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
        MemRead_EXMEM  = (k == 1) || (k == 3);
        MemWrite_EXMEM = (k == 2) || (k == 3);
        addr_EXMEM     = a;
        wdata_EXMEM    = 16'($urandom);
    endtask

    initial begin
        m_served = 0; m_pending = 0; m_err = 0; m_hold = 16'h0000; m_waited = 0; strobes = 0;
        rst = 1'b1;
        set_in(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0);
        @(posedge clk); #1;
        tick();
        rst = 1'b0;

        // Reset state with a pass-through address
        set_in(0, 0, 16'h1234, 16'h5678, 0, 0, 16'h0000, 0, 0);
        step("reset");
        chk16("reset_addr", mem_Addr, 16'h1234);
        chk16("reset_wdata", mem_DataIn, 16'h5678);
        chk1("reset_stall", data_mem_stall, 1'b0);
        tick();

        // Load hit
        set_in(1, 0, 16'h0010, 16'h0000, 1, 1, 16'hBEEF, 0, 0);
        step("hit");
        chk16("hit_rdata", mem_read_data, 16'hBEEF);
        chk1("hit_rd", mem_Rd, 1'b1);
        chk1("hit_stall", data_mem_stall, 1'b0);
        tick();

        // Store miss, done four cycles after the request
        stall_cnt = 0; wr_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            set_in(0, 1, 16'h0020, 16'hA5A5, k == 4, k == 4, 16'h0000, 0, 0);
            step("miss");
            if (data_mem_stall) stall_cnt++;
            if (mem_Wr) wr_cnt++;
            if (k == 4) chk1("miss_done5", data_mem_done, 1'b1);
            tick();
        end
        chk16("miss_stall_cycles", 16'(stall_cnt), 16'd4);
        chk16("miss_wr_pulses", 16'(wr_cnt), 16'd1);

        // Held pipeline after a hit
        for (int k = 0; k < 5; k++) begin
            set_in(1, 0, 16'h0030, 16'h0000, k == 4, k == 0, (k == 0) ? 16'h1234 : 16'hDEAD, 0, 0);
            step("held");
            if (k > 0) begin
                chk16("held_rdata", mem_read_data, 16'h1234);
                chk1("held_done", data_mem_done, 1'b1);
                chk1("held_rd", mem_Rd, 1'b0);
            end
            tick();
        end

        // Misaligned load
        set_in(1, 0, 16'h0011, 16'h0000, 1, 0, 16'h0000, 0, 0);
        step("misal");
        chk1("misal_rd", mem_Rd, 1'b0);
        chk1("misal_err", data_mem_err, 1'b1);
        chk1("misal_stall", data_mem_stall, 1'b0);
        tick();

        // Busy cache for two cycles
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 16'h0040, 16'h0000, k == 2, k == 2, 16'h0042, k < 2, 0);
            step("busy");
            if (k < 2) begin
                chk1("busy_stall", data_mem_stall, 1'b1);
                chk1("busy_rd", mem_Rd, 1'b0);
            end else begin
                chk1("busy_strobe", mem_Rd, 1'b1);
                chk1("busy_release", data_mem_stall, 1'b0);
            end
            tick();
        end

        // Completion with error together with advance, then a fresh instruction
        set_in(0, 1, 16'h0050, 16'h1111, 0, 0, 16'h0000, 0, 0);
        step("advdone"); tick();
        set_in(0, 1, 16'h0050, 16'h1111, 1, 1, 16'h5555, 0, 1);
        step("advdone");
        chk1("advdone_err", data_mem_err, 1'b1);
        tick();
        set_in(1, 0, 16'h0052, 16'h0000, 1, 1, 16'h6666, 0, 0);
        step("next");
        chk1("next_rd", mem_Rd, 1'b1);
        chk1("next_err", data_mem_err, 1'b0);
        tick();

        // Reset in the middle of WAIT, then a late completion
        set_in(1, 0, 16'h0060, 16'h0000, 0, 0, 16'h0000, 0, 0);
        step("prerst"); tick();
        step("prerst"); tick();
        rst = 1'b1;
        set_in(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0);
        tick();
        rst = 1'b0;
        step("postrst");
        chk1("postrst_stall", data_mem_stall, 1'b0);
        chk1("postrst_done", data_mem_done, 1'b0);
        chk1("postrst_err", data_mem_err, 1'b0);
        chk16("postrst_rdata", mem_read_data, 16'h0000);
        set_in(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h7777, 0, 0);
        tick();
        set_in(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0);
        step("late");
        chk1("late_done", data_mem_done, 1'b0);
        chk16("late_rdata", mem_read_data, 16'h0000);
        tick();

`ifdef MEM_TIMEOUT_EN
        // Watchdog: no completion ever arrives
        stall_cnt = 0;
        for (int k = 0; k < 34; k++) begin
            set_in(0, 1, 16'h0070, 16'h0F0F, 0, 0, 16'h0000, 0, 0);
            step("to");
            if (data_mem_stall) stall_cnt++;
            tick();
        end
        step("to_end");
        chk1("to_err", data_mem_err, 1'b1);
        chk1("to_stall", data_mem_stall, 1'b0);
        chk16("to_stall_cycles", 16'(stall_cnt), 16'(TO_CYCLES + 1));
        advance = 1'b1;
        step("to_adv");
        tick();
`endif

        // Randomized traffic against the model
        set_in(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0);
        new_instr();
        for (int i = 0; i < 600; i++) begin
            advance = 1'b0;
            if (m_pending) begin
                mem_Stall = 1'($urandom_range(0, 1));
                mem_Done  = ($urandom_range(0, 2) == 0);
            end else begin
                mem_Stall = ($urandom_range(0, 3) == 0);
                mem_Done  = 1'b0;
                calc();
                mem_Done  = issue && ($urandom_range(0, 1) == 1);
            end
            mem_DataOut = 16'($urandom);
            mem_err     = ($urandom_range(0, 7) == 0);
            calc();
            advance = !e_stall && ($urandom_range(0, 1) == 1);
            step("rnd");
            tick();
            if (advance) new_instr();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
